// File: rtl/a2d_rr_intf.sv
// rtl/a2d_rr_intf.sv - round-robin ADC128S SPI reader; A2D_BATT_CH_EN adds battery channel 6
module a2d_rr_intf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);
    typedef enum logic [2:0] {IDLE, CMD, PAUSE, READ, DONE} state_t;

    localparam logic [4:0] DIV_LOAD = 5'b10111;

    state_t      r_state;
    logic [4:0]  r_sclk_div;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_shft;
    logic        r_miso;
    logic        r_porch;
    logic        r_ss_n;
    logic        r_cnv_cmplt;
    logic [1:0]  r_ptr;
    logic [11:0] r_lft;
    logic [11:0] r_rght;
    logic [11:0] r_steer;
`ifdef A2D_BATT_CH_EN
    logic [11:0] r_batt;
`endif

    logic [1:0]  w_ptr_nxt;
    logic [2:0]  w_chnl;
    logic [15:0] w_cmd;
    logic        w_last_shft;

    always_comb begin
        w_chnl = 3'd0;
        case (r_ptr)
            2'd0:    w_chnl = 3'd0;
            2'd1:    w_chnl = 3'd4;
            2'd2:    w_chnl = 3'd5;
            default: w_chnl = 3'd6;
        endcase
    end

    assign w_cmd = {2'b00, w_chnl, 11'h000};

`ifdef A2D_BATT_CH_EN
    assign w_ptr_nxt = r_ptr + 2'd1;
`else
    assign w_ptr_nxt = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
`endif

    assign w_last_shft = (r_sclk_div == 5'b11111) && !r_porch && (r_bit_cnt == 5'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sclk_div  <= DIV_LOAD;
            r_bit_cnt   <= 5'd0;
            r_shft      <= 16'h0000;
            r_miso      <= 1'b0;
            r_porch     <= 1'b1;
            r_ss_n      <= 1'b1;
            r_cnv_cmplt <= 1'b0;
            r_ptr       <= 2'd0;
            r_lft       <= 12'h000;
            r_rght      <= 12'h000;
            r_steer     <= 12'h000;
`ifdef A2D_BATT_CH_EN
            r_batt      <= 12'h000;
`endif
        end else begin
            r_cnv_cmplt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (nxt) begin
                        r_shft     <= w_cmd;
                        r_sclk_div <= DIV_LOAD;
                        r_bit_cnt  <= 5'd0;
                        r_porch    <= 1'b1;
                        r_state    <= CMD;
                    end
                end
                CMD, READ: begin
                    if (r_ss_n)
                        r_ss_n <= 1'b0;
                    if (r_sclk_div == 5'b01111)
                        r_miso <= MISO;
                    // Divider freezes at 31 on the last shift so SCLK never toggles as SS_n rises
                    if (w_last_shft) begin
                        r_shft    <= {r_shft[14:0], r_miso};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        r_ss_n    <= 1'b1;
                        r_state   <= (r_state == CMD) ? PAUSE : DONE;
                    end else begin
                        r_sclk_div <= r_sclk_div + 5'd1;
                        if (r_sclk_div == 5'b11111) begin
                            r_porch <= 1'b0;
                            if (!r_porch) begin
                                r_shft    <= {r_shft[14:0], r_miso};
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    r_shft     <= w_cmd;
                    r_sclk_div <= DIV_LOAD;
                    r_bit_cnt  <= 5'd0;
                    r_porch    <= 1'b1;
                    r_state    <= READ;
                end
                DONE: begin
                    case (r_ptr)
                        2'd0: r_lft   <= r_shft[11:0];
                        2'd1: r_rght  <= r_shft[11:0];
                        2'd2: r_steer <= r_shft[11:0];
                        default: begin
`ifdef A2D_BATT_CH_EN
                            r_batt <= r_shft[11:0];
`endif
                        end
                    endcase
                    r_cnv_cmplt <= 1'b1;
                    r_ptr       <= w_ptr_nxt;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign SS_n      = r_ss_n;
    assign SCLK      = r_ss_n | r_sclk_div[4];
    assign MOSI      = r_shft[15];
    assign cnv_cmplt = r_cnv_cmplt;
    assign lft_ld    = r_lft;
    assign rght_ld   = r_rght;
    assign steer_pot = r_steer;
`ifdef A2D_BATT_CH_EN
    assign batt      = r_batt;
`else
    assign batt      = 12'h000;
`endif

endmodule

// File: tb/tb_a2d_rr_intf.sv
// tb/tb_a2d_rr_intf.sv - scoreboard bench for a2d_rr_intf with an ADC128S slave model
module tb_a2d_rr_intf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        MISO;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        cnv_cmplt, SS_n, SCLK, MOSI;

    int n_checks = 0;
    int n_errors = 0;
    int cnv_count = 0;

    logic [11:0] adc_data [8];
    logic [15:0] adc_tx = 16'h0000;
    logic [15:0] adc_rx = 16'h0000;
    logic        adc_first = 1'b1;
    logic [2:0]  adc_last_ch = 3'd0;

    logic [15:0] exp_cmd [$];
    int          exp_res [$];
    logic [11:0] exp_out [4];

`ifdef A2D_BATT_CH_EN
    int seq [8] = '{0, 4, 5, 6, 0, 4, 5, 6};
`else
    int seq [8] = '{0, 4, 5, 0, 4, 5, 0, 4};
`endif

    a2d_rr_intf dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt), .MISO(MISO),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
        .cnv_cmplt(cnv_cmplt), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [15:0] cmd_of(input int ch);
        logic [2:0] c;
        c = ch[2:0];
        return {2'b00, c, 11'h000};
    endfunction

    function automatic int out_idx(input int ch);
        case (ch)
            0:       return 0;
            4:       return 1;
            5:       return 2;
            default: return 3;
        endcase
    endfunction

    // ADC slave, mode 3: shifts out {4'hA, data} on SCLK falls, captures MOSI on rises
    assign MISO = adc_tx[15];

    always @(negedge SS_n or negedge SCLK) begin
        if (!SS_n && rst_n) begin
            if (SCLK) begin
                adc_tx    = {4'hA, adc_data[adc_last_ch]};
                adc_first = 1'b1;
            end else if (adc_first) begin
                adc_first = 1'b0;
            end else begin
                adc_tx = {adc_tx[14:0], 1'b0};
            end
        end
    end

    always @(posedge SCLK) begin
        if (!SS_n && rst_n)
            adc_rx = {adc_rx[14:0], MOSI};
    end

    always @(posedge SS_n) begin
        if (rst_n) begin
            adc_last_ch = adc_rx[13:11];
            if (exp_cmd.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL cmd_unexpected: got %h expected no transaction", adc_rx);
            end else begin
                chk("mosi_cmd", adc_rx, exp_cmd.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cnv_cmplt === 1'b1) begin
            cnv_count++;
            if (exp_res.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL cnv_unexpected: got cnv_cmplt expected none");
            end else begin
                int ch;
                ch = exp_res.pop_front();
                exp_out[out_idx(ch)] = adc_data[ch[2:0]];
                chk("outputs", {lft_ld, rght_ld, steer_pot, batt},
                    {exp_out[0], exp_out[1], exp_out[2], exp_out[3]});
            end
        end
    end

    task automatic pulse_nxt;
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
    endtask

    task automatic wait_cnv(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 1200 && !seen; k++) begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no cnv_cmplt expected one within 1200 clks", name);
        end
    endtask

    task automatic do_conv(input int ch);
        exp_cmd.push_back(cmd_of(ch));
        exp_cmd.push_back(cmd_of(ch));
        exp_res.push_back(ch);
        pulse_nxt();
        wait_cnv("conv_timeout");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_f1, t_f2, t_r1, t_r2, sc1, sc2, t_c, mosi_bad, c0;
        logic prev_ss, prev_sclk, prev_mosi;

        for (int i = 0; i < 8; i++) adc_data[i] = 12'h000;
        for (int i = 0; i < 4; i++) exp_out[i] = 12'h000;
        adc_data[0] = 12'h123;
        adc_data[4] = 12'hABC;
        adc_data[5] = 12'h800;
        adc_data[6] = 12'hDA0;

        repeat (2) @(negedge clk);
        chk("reset_pins", {SS_n, SCLK, MOSI, cnv_cmplt}, 4'b1100);
        chk("reset_outputs", {lft_ld, rght_ld, steer_pot, batt}, 48'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_pins", {SS_n, SCLK, cnv_cmplt}, 3'b110);

        // First conversion with cycle-accurate timing trace
        exp_cmd.push_back(cmd_of(seq[0]));
        exp_cmd.push_back(cmd_of(seq[0]));
        exp_res.push_back(seq[0]);
        t_f1 = -1; t_f2 = -1; t_r1 = -1; t_r2 = -1; sc1 = -1; sc2 = -1; t_c = -1;
        mosi_bad = 0;
        @(negedge clk);
        nxt = 1'b1;
        prev_ss = SS_n; prev_sclk = SCLK; prev_mosi = MOSI;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (k == 1) nxt = 1'b0;
            if (prev_ss && !SS_n) begin
                if (t_f1 < 0) t_f1 = k; else if (t_f2 < 0) t_f2 = k;
            end
            if (!prev_ss && SS_n) begin
                if (t_r1 < 0) t_r1 = k; else if (t_r2 < 0) t_r2 = k;
            end
            if (prev_sclk && !SCLK) begin
                if (sc1 < 0) sc1 = k; else if (sc2 < 0) sc2 = k;
            end
            if (!SS_n && !prev_ss && (MOSI !== prev_mosi) && !(prev_sclk && !SCLK))
                mosi_bad++;
            if (cnv_cmplt === 1'b1 && t_c < 0) t_c = k;
            prev_ss = SS_n; prev_sclk = SCLK; prev_mosi = MOSI;
        end
        chk("nxt_to_ss_fall", t_f1, 2);
        chk("ss_low_cmd", t_r1 - t_f1, 520);
        chk("ss_pause", t_f2 - t_r1, 2);
        chk("ss_low_read", t_r2 - t_f2, 520);
        chk("sclk_front_porch", sc1 - t_f1, 8);
        chk("sclk_period", sc2 - sc1, 32);
        chk("cnv_latency", t_c, 1045);
        chk("mosi_on_fall_only", mosi_bad, 0);

        for (int i = 1; i <= 4; i++) do_conv(seq[i]);

        // nxt during CMD must be dropped
        c0 = cnv_count;
        exp_cmd.push_back(cmd_of(seq[5]));
        exp_cmd.push_back(cmd_of(seq[5]));
        exp_res.push_back(seq[5]);
        pulse_nxt();
        repeat (300) @(negedge clk);
        pulse_nxt();
        wait_cnv("ignored_nxt_timeout");
        repeat (1200) @(negedge clk);
        chk("ignored_nxt_cnv_count", cnv_count - c0, 1);
        do_conv(seq[6]);

        // Reset in the middle of the READ transaction
        exp_cmd.push_back(cmd_of(seq[7]));
        pulse_nxt();
        repeat (700) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_pins", {SS_n, SCLK, cnv_cmplt}, 3'b110);
        chk("midreset_lft", lft_ld, 12'h000);
        chk("cmd_before_reset", exp_cmd.size(), 0);
        exp_cmd.delete();
        exp_res.delete();
        for (int i = 0; i < 4; i++) exp_out[i] = 12'h000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_conv(0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
